// File: rtl/srl_delay_ctrl.sv
// Sample-count delay line: an unreset shift chain (maps onto SRL primitives)
// plus the control that gates the shift, tracks fill, picks the read tap and drains on flush.
module srl_delay_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int DEFAULT_LEN = 8,
    parameter int LEN_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             cfg_load_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    output logic             cfg_err_o,
    input  logic             flush_req_i,
    output logic [LEN_W-1:0] fill_level_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   flushCnt_q;
    logic               outValid_q;
    logic               outLast_q;
    logic [WIDTH-1:0]   outData_q;
    logic               cfgErr_q;
    logic [WIDTH-1:0]   chain_q [DEPTH];

    logic               push;
    logic               cfgLenOk;
    logic [LEN_W-1:0]   tapIdx;
    logic [WIDTH-1:0]   tapData;
    logic [LEN_W-1:0]   fillInc_d;

    assign in_ready_o = (state_q != FLUSH) && !flush_req_i && !cfg_load_i;
    assign push       = in_valid_i && in_ready_o;
    assign cfgLenOk   = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(DEPTH));
    assign fillInc_d  = fill_q + LEN_W'(1);

    // The data chain carries no reset so synthesis can pack it into shift-register primitives.
    always_ff @(posedge clk_i) begin
        if (push) begin
            chain_q[0] <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    // Dynamic tap: the oldest held sample while draining, otherwise the sample len pushes back.
    always_comb begin
        tapIdx  = (state_q == FLUSH) ? (flushCnt_q - LEN_W'(1)) : (len_q - LEN_W'(1));
        tapData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tapIdx == LEN_W'(i)) begin
                tapData = chain_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FILL;
            len_q      <= LEN_W'(DEFAULT_LEN);
            fill_q     <= '0;
            flushCnt_q <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= '0;
            cfgErr_q   <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            cfgErr_q   <= 1'b0;
            if (cfg_load_i && cfgLenOk) begin
                // A new length discards held samples and aborts any drain silently.
                len_q      <= cfg_len_i;
                fill_q     <= '0;
                flushCnt_q <= '0;
                state_q    <= FILL;
            end else begin
                if (cfg_load_i) begin
                    cfgErr_q <= 1'b1;
                end
                unique case (state_q)
                    FILL: begin
                        if (flush_req_i && !cfg_load_i) begin
                            if (fill_q != '0) begin
                                flushCnt_q <= fill_q;
                                state_q    <= FLUSH;
                            end
                        end else if (push) begin
                            fill_q <= fillInc_d;
                            if (fillInc_d == len_q) begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (flush_req_i && !cfg_load_i) begin
                            flushCnt_q <= fill_q;
                            state_q    <= FLUSH;
                        end else if (push) begin
                            outValid_q <= 1'b1;
                            outData_q  <= tapData;
                        end
                    end
                    FLUSH: begin
                        outValid_q <= 1'b1;
                        outData_q  <= tapData;
                        flushCnt_q <= flushCnt_q - LEN_W'(1);
                        fill_q     <= fill_q - LEN_W'(1);
                        if (flushCnt_q == LEN_W'(1)) begin
                            outLast_q <= 1'b1;
                            fill_q    <= '0;
                            state_q   <= FILL;
                        end
                    end
                    default: begin
                        state_q <= FILL;
                    end
                endcase
            end
        end
    end

    assign out_valid_o  = outValid_q;
    assign out_data_o   = outData_q;
    assign out_last_o   = outLast_q;
    assign cfg_err_o    = cfgErr_q;
    assign fill_level_o = fill_q;
    assign busy_o       = (state_q == FLUSH);

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Bench for srl_delay_ctrl: directed vector table, hand-built flush/reset sequences,
// and random traffic, all scored against a sample-queue model of the delay line.
module tb_srl_delay_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int DEFAULT_LEN = 8;
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             inValid = 1'b0;
    logic             inReady;
    logic [WIDTH-1:0] inData = '0;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic             outLast;
    logic             cfgLoad = 1'b0;
    logic [LEN_W-1:0] cfgLen = '0;
    logic             cfgErr;
    logic             flushReq = 1'b0;
    logic [LEN_W-1:0] fillLevel;
    logic             busy;

    int numChecks = 0;
    int numPass = 0;

    srl_delay_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DEFAULT_LEN(DEFAULT_LEN), .LEN_W(LEN_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData),
        .out_valid_o(outValid), .out_data_o(outData), .out_last_o(outLast),
        .cfg_load_i(cfgLoad), .cfg_len_i(cfgLen), .cfg_err_o(cfgErr),
        .flush_req_i(flushReq), .fill_level_o(fillLevel), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Reference model: history of accepted samples (newest first) and a drain queue.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] drain[$];
    bit               mFlushing = 0;
    int               mLen = DEFAULT_LEN;
    int               mFill = 0;
    logic             expValid = 0;
    logic [WIDTH-1:0] expData = '0;
    logic             expLast = 0;
    logic             expErr = 0;

    typedef struct {
        logic             rst;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             cfgLoad;
        logic [LEN_W-1:0] cfgLen;
        logic             flush;
        logic             expValid;
        logic [WIDTH-1:0] expData;
        logic             expErr;
        logic [LEN_W-1:0] expFill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act === exp) begin
            numPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void addVec(input logic r, input logic v, input logic [WIDTH-1:0] d,
                                   input logic cl, input logic [LEN_W-1:0] cln, input logic f,
                                   input logic ev, input logic [WIDTH-1:0] ed,
                                   input logic ee, input logic [LEN_W-1:0] ef);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.cfgLoad = cl; x.cfgLen = cln; x.flush = f;
        x.expValid = ev; x.expData = ed; x.expErr = ee; x.expFill = ef;
        vecs.push_back(x);
    endfunction

    function automatic void modelStep(input logic r, input logic v, input logic [WIDTH-1:0] d,
                                      input logic cl, input logic [LEN_W-1:0] cln, input logic f);
        expValid = 0;
        expLast = 0;
        expErr = 0;
        if (r) begin
            mFlushing = 0;
            drain.delete();
            mLen = DEFAULT_LEN;
            mFill = 0;
            expData = '0;
        end else if (cl && cln >= 1 && int'(cln) <= DEPTH) begin
            mLen = int'(cln);
            mFill = 0;
            mFlushing = 0;
            drain.delete();
        end else begin
            if (cl) expErr = 1;
            if (mFlushing) begin
                expValid = 1;
                expData = drain.pop_front();
                mFill = mFill - 1;
                if (drain.size() == 0) begin
                    expLast = 1;
                    mFill = 0;
                    mFlushing = 0;
                end
            end else if (!cl && f) begin
                if (mFill > 0) begin
                    for (int k = mFill - 1; k >= 0; k--) drain.push_back(hist[k]);
                    mFlushing = 1;
                end
            end else if (!cl && v) begin
                if (mFill == mLen) begin
                    expValid = 1;
                    expData = hist[mLen-1];
                end else begin
                    mFill = mFill + 1;
                end
                hist.push_front(d);
                if (hist.size() > 40) void'(hist.pop_back());
            end
        end
    endfunction

    task automatic checkOutput(input string tag);
        check({tag, " out_valid"}, 32'(outValid), 32'(expValid));
        check({tag, " out_data"}, 32'(outData), 32'(expData));
        check({tag, " out_last"}, 32'(outLast), 32'(expLast));
        check({tag, " cfg_err"}, 32'(cfgErr), 32'(expErr));
        check({tag, " fill_level"}, 32'(fillLevel), 32'(mFill));
        check({tag, " busy"}, 32'(busy), 32'(mFlushing));
    endtask

    // One clock: drive inputs, check in_ready, advance DUT and model, compare outputs.
    task automatic applyStimulus(input string tag, input logic r, input logic v,
                                 input logic [WIDTH-1:0] d, input logic cl,
                                 input logic [LEN_W-1:0] cln, input logic f);
        rst = r; inValid = v; inData = d; cfgLoad = cl; cfgLen = cln; flushReq = f;
        #1;
        if (!r) check({tag, " in_ready"}, 32'(inReady), 32'(!mFlushing && !f && !cl));
        modelStep(r, v, d, cl, cln, f);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag, input logic v);
        applyStimulus(tag, 1'b0, v, 8'hEE, 1'b0, '0, 1'b0);
    endtask

    task automatic pushN(input string tag, input logic [WIDTH-1:0] first, input int n);
        for (int k = 0; k < n; k++) applyStimulus(tag, 1'b0, 1'b1, first + WIDTH'(k), 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Back-to-back stream with len 8, then one idle cycle.
        addVec(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 10; k++)
            addVec(0, 1, WIDTH'(k), 0, 0, 0, k > 8, (k > 8) ? WIDTH'(k - 8) : 8'h00, 0, (k > 8) ? 5'd8 : LEN_W'(k));
        addVec(0, 0, 0, 0, 0, 0, 0, 8'h02, 0, 8);
        // Same stream with a gap after every sample.
        addVec(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            addVec(0, 1, WIDTH'(k), 0, 0, 0, k > 8, (k > 8) ? WIDTH'(k - 8) : 8'h00, 0, (k > 8) ? 5'd8 : LEN_W'(k));
            addVec(0, 0, 8'hFF, 0, 0, 0, 0, (k > 8) ? WIDTH'(k - 8) : 8'h00, 0, (k > 8) ? 5'd8 : LEN_W'(k));
        end
        // Reprogram to len 3 with 5 samples held.
        addVec(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 5; k++) addVec(0, 1, WIDTH'(k), 0, 0, 0, 0, 8'h00, 0, LEN_W'(k));
        addVec(0, 1, 8'h77, 1, 3, 0, 0, 8'h00, 0, 0);
        addVec(0, 1, 8'h0A, 0, 0, 0, 0, 8'h00, 0, 1);
        addVec(0, 1, 8'h0B, 0, 0, 0, 0, 8'h00, 0, 2);
        addVec(0, 1, 8'h0C, 0, 0, 0, 0, 8'h00, 0, 3);
        addVec(0, 1, 8'h0D, 0, 0, 0, 1, 8'h0A, 0, 3);
        // Out-of-range lengths are rejected and len stays 8.
        addVec(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        addVec(0, 0, 0, 1, 17, 0, 0, 8'h00, 1, 0);
        for (int k = 0; k <= 8; k++)
            addVec(0, 1, 8'h40 + WIDTH'(k), 0, 0, 0, k == 8, (k == 8) ? 8'h40 : 8'h00, 0, (k == 8) ? 5'd8 : LEN_W'(k + 1));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].rst, vecs[i].valid, vecs[i].data,
                          vecs[i].cfgLoad, vecs[i].cfgLen, vecs[i].flush);
            check($sformatf("vec%0d tbl valid", i), 32'(outValid), 32'(vecs[i].expValid));
            check($sformatf("vec%0d tbl data", i), 32'(outData), 32'(vecs[i].expData));
            check($sformatf("vec%0d tbl err", i), 32'(cfgErr), 32'(vecs[i].expErr));
            check($sformatf("vec%0d tbl fill", i), 32'(fillLevel), 32'(vecs[i].expFill));
        end

        // Flush of three held samples, oldest first, with a last marker.
        applyStimulus("fl rst", 1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        applyStimulus("fl p", 1'b0, 1'b1, 8'h11, 1'b0, '0, 1'b0);
        applyStimulus("fl p", 1'b0, 1'b1, 8'h22, 1'b0, '0, 1'b0);
        applyStimulus("fl p", 1'b0, 1'b1, 8'h33, 1'b0, '0, 1'b0);
        applyStimulus("fl t", 1'b0, 1'b1, 8'h44, 1'b0, '0, 1'b1);
        check("fl t+1 busy", 32'(busy), 32'd1);
        idle("fl t+1", 1'b1);
        check("fl t+2 data", 32'(outData), 32'h11);
        check("fl t+2 valid", 32'(outValid), 32'd1);
        idle("fl t+2", 1'b1);
        check("fl t+3 data", 32'(outData), 32'h22);
        check("fl t+3 last", 32'(outLast), 32'd0);
        idle("fl t+3", 1'b1);
        check("fl t+4 data", 32'(outData), 32'h33);
        check("fl t+4 last", 32'(outLast), 32'd1);
        check("fl t+4 fill", 32'(fillLevel), 32'd0);
        #1;
        check("fl t+4 ready", 32'(inReady), 32'd1);
        idle("fl t+4", 1'b0);
        check("fl t+5 valid", 32'(outValid), 32'd0);

        // Reset landing in the middle of a flush.
        applyStimulus("fr rst", 1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        pushN("fr p", 8'h11, 3);
        applyStimulus("fr t", 1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1);
        idle("fr t+1", 1'b0);
        applyStimulus("fr t+2", 1'b1, 1'b0, 8'h00, 1'b0, '0, 1'b0);
        check("fr t+3 valid", 32'(outValid), 32'd0);
        check("fr t+3 busy", 32'(busy), 32'd0);
        check("fr t+3 fill", 32'(fillLevel), 32'd0);
        #1;
        check("fr t+3 ready", 32'(inReady), 32'd1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus("fr p8", 1'b0, 1'b1, 8'hA0 + WIDTH'(k), 1'b0, '0, 1'b0);
            check("fr p8 no out", 32'(outValid), 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic r, v, cl, f;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 39) == 0);
            f  = ($urandom_range(0, 29) == 0);
            applyStimulus("rnd", r, v, WIDTH'($urandom), cl, LEN_W'($urandom_range(0, 20)), f);
        end

        $display("[TB] %0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule
